// File: rtl/rv_pkg.sv
// rv_pkg: shared RV32I opcodes, immediate formats and the decoded bundle reused by execute
package rv_pkg;
  localparam int XLEN = 32;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_MISC   = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_value;
    logic [XLEN-1:0] rs2_value;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd_addr;
    logic            rd_wen;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7_b5;
    logic            illegal;
  } decode_bundle_t;
  function automatic imm_fmt_e imm_fmt(input logic [6:0] op);
    case (op)
      OP_LUI, OP_AUIPC: return IMM_U;
      OP_JAL:           return IMM_J;
      OP_BRANCH:        return IMM_B;
      OP_STORE:         return IMM_S;
      OP_JALR, OP_LOAD, OP_OPIMM, OP_MISC, OP_SYSTEM: return IMM_I;
      default:          return IMM_NONE;
    endcase
  endfunction
endpackage

// File: rtl/decode_imm_gen.sv
// decode_imm_gen: combinational RV32I immediate extraction, zero for illegal opcodes
module decode_imm_gen import rv_pkg::*; (
  input  logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] imm
);
  imm_fmt_e fmt;
  logic [19:0] sx;
  assign fmt = imm_fmt(instr[6:0]);
  assign sx = {20{instr[31]}};
  always_comb
    imm = fmt == IMM_I ? {sx, instr[31:20]} :
          fmt == IMM_S ? {sx, instr[31:25], instr[11:7]} :
          fmt == IMM_B ? {sx[18:0], instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} :
          fmt == IMM_U ? {instr[31:12], 12'h000} :
          fmt == IMM_J ? {sx[10:0], instr[31], instr[19:12], instr[20], instr[30:21], 1'b0} : '0;
endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode with registered bundle; DECODE_SCOREBOARD_EN adds a RAW/WAW interlock
module decode_stage import rv_pkg::*; (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_value,
  input  logic [XLEN-1:0] rs2_value,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_rs1_value,
  output logic [XLEN-1:0] out_rs2_value,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rd_addr,
  output logic            out_rd_wen,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic            out_funct7_b5,
  output logic            out_illegal,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd_addr
);
  logic [6:0] op;
  logic [4:0] rd;
  logic [XLEN-1:0] imm;
  logic legal, rd_wen, hazard, capture;
  decode_bundle_t q, nxt;
  assign op = in_instr[6:0];
  assign rd = in_instr[11:7];
  assign rs1_addr = in_instr[19:15];
  assign rs2_addr = in_instr[24:20];
  assign legal = imm_fmt(op) != IMM_NONE || op == OP_OP;
  assign rd_wen = op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_OPIMM, OP_OP} && rd != 5'd0;
  decode_imm_gen u_imm (.instr(in_instr), .imm(imm));
`ifdef DECODE_SCOREBOARD_EN
  logic rs1_used, rs2_used;
  logic [31:0] busy, pend, set_mask, clr_mask;
  assign rs1_used = op inside {OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_OPIMM, OP_OP};
  assign rs2_used = op inside {OP_BRANCH, OP_STORE, OP_OP};
  // the held bundle has not issued yet, so its rd is pending without a busy bit
  assign pend = busy | (out_valid && q.rd_wen ? 32'd1 << q.rd_addr : 32'd0);
  assign hazard = (rs1_used && pend[rs1_addr]) || (rs2_used && pend[rs2_addr]) || (rd_wen && pend[rd]);
  assign set_mask = out_valid && out_ready && q.rd_wen && !flush ? 32'd1 << q.rd_addr : 32'd0;
  assign clr_mask = wb_valid ? 32'd1 << wb_rd_addr : 32'd0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) busy <= '0;
    else busy <= ((busy & ~clr_mask) | set_mask) & ~32'd1;
`else
  logic unused_wb;
  assign unused_wb = ^{wb_valid, wb_rd_addr};
  assign hazard = 1'b0;
`endif
  assign in_ready = !flush && !hazard && (!out_valid || out_ready);
  assign capture = in_valid && in_ready;
  always_comb
    nxt = '{pc: in_pc, rs1_value: rs1_value, rs2_value: rs2_value, imm: imm,
            rd_addr: rd, rd_wen: rd_wen, opcode: op, funct3: in_instr[14:12],
            funct7_b5: in_instr[30], illegal: !legal};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      q <= '0;
    end else if (flush) out_valid <= 1'b0;
    else if (capture) begin
      out_valid <= 1'b1;
      q <= nxt;
    end else if (out_ready) out_valid <= 1'b0;
  assign out_pc = q.pc;
  assign out_rs1_value = q.rs1_value;
  assign out_rs2_value = q.rs2_value;
  assign out_imm = q.imm;
  assign out_rd_addr = q.rd_addr;
  assign out_rd_wen = q.rd_wen;
  assign out_opcode = q.opcode;
  assign out_funct3 = q.funct3;
  assign out_funct7_b5 = q.funct7_b5;
  assign out_illegal = q.illegal;
endmodule
